// File: rtl/alu.sv
// 16-bit execute-stage ALU: combinational result/address, registered C/Z/N/V flags.
// Result has zero latency; flags update one edge after a valid ALU-class instruction; no backpressure.
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  opcode,
  input  logic [3:0]  alu_op,
  input  logic [15:0] lhs,
  input  logic [15:0] rhs,
  input  logic        bubble,
  output logic [15:0] result,
  output logic [3:0]  flags
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_ADDC = 4'd1,  OP_SUB  = 4'd2,  OP_SUBC = 4'd3,
    OP_AND  = 4'd4,  OP_NAND = 4'd5,  OP_OR   = 4'd6,  OP_XOR  = 4'd7,
    OP_NOT  = 4'd8,  OP_SHL  = 4'd9,  OP_SHR  = 4'd10, OP_ROTL = 4'd11,
    OP_ROTR = 4'd12, OP_SSHR = 4'd13, OP_SHLC = 4'd14, OP_SHRC = 4'd15
  } alu_op_e;

  logic [3:0]  flags_q, flags_d;
  logic        c_q;
  logic [3:0]  amt;
  logic [4:0]  amt_inv;
  logic        is_sub;
  logic [15:0] b_op;
  logic        cin;
  logic [16:0] sum;
  logic [15:0] addr;
  logic [16:0] shl_w, shr_w, sshr_w;
  logic [15:0] rotl_w, rotr_w;
  logic [15:0] alu_res;
  logic        alu_c, alu_v;
  alu_op_e     op;

  assign op      = alu_op_e'(alu_op);
  assign c_q     = flags_q[0];
  assign amt     = rhs[3:0];
  assign amt_inv = 5'd16 - {1'b0, amt};

  // Subtraction is lhs + ~rhs + cin, so one adder and one overflow rule cover all four.
  assign is_sub = (op == OP_SUB) || (op == OP_SUBC);
  assign b_op   = is_sub ? ~rhs : rhs;
  assign sum    = {1'b0, lhs} + {1'b0, b_op} + {16'b0, cin};
  assign addr   = lhs + rhs;

  // Extra bit on each shifter catches the last bit shifted out (zero when amt is 0).
  assign shl_w  = {1'b0, lhs} << amt;
  assign shr_w  = {lhs, 1'b0} >> amt;
  assign sshr_w = $signed({lhs, 1'b0}) >>> amt;
  assign rotl_w = (lhs << amt) | (lhs >> amt_inv);
  assign rotr_w = (lhs >> amt) | (lhs << amt_inv);

  always_comb begin
    cin = 1'b0;
    case (op)
      OP_ADDC, OP_SUBC: cin = c_q;
      OP_SUB:           cin = 1'b1;
      default:          cin = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = 16'h0000;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: begin
        alu_res = sum[15:0];
        alu_c   = sum[16];
        alu_v   = (lhs[15] == b_op[15]) && (sum[15] != lhs[15]);
      end
      OP_AND:  alu_res = lhs & rhs;
      OP_NAND: alu_res = ~(lhs & rhs);
      OP_OR:   alu_res = lhs | rhs;
      OP_XOR:  alu_res = lhs ^ rhs;
      OP_NOT:  alu_res = ~lhs;
      OP_SHL:  {alu_c, alu_res} = shl_w;
      OP_SHR:  {alu_res, alu_c} = shr_w;
      OP_SSHR: {alu_res, alu_c} = sshr_w;
      OP_ROTL: begin
        alu_res = rotl_w;
        alu_c   = (amt != 4'd0) & rotl_w[0];
      end
      OP_ROTR: begin
        alu_res = rotr_w;
        alu_c   = (amt != 4'd0) & rotr_w[15];
      end
      OP_SHLC: begin
        alu_res = {lhs[14:0], c_q};
        alu_c   = lhs[15];
      end
      OP_SHRC: begin
        alu_res = {c_q, lhs[15:1]};
        alu_c   = lhs[0];
      end
      default: alu_res = 16'h0000;
    endcase
  end

  always_comb begin
    result = addr;
    case (opcode)
      3'b000, 3'b001: result = alu_res;
      3'b011, 3'b111: result = lhs;
      default:        result = addr;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (!bubble && (opcode[2:1] == 2'b00))
      flags_d = {alu_v, alu_res[15], (alu_res == 16'h0000), alu_c};
  end

  always_ff @(posedge clk) begin
    if (rst) flags_q <= 4'b0000;
    else     flags_q <= flags_d;
  end

  assign flags = flags_q;

endmodule

// File: tb/tb_alu.sv
// Randomized and directed checks of alu against an arithmetic reference model.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  opcode;
  logic [3:0]  alu_op;
  logic [15:0] lhs, rhs;
  logic        bubble;
  logic [15:0] result;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_fails  = 0;
  logic [3:0]  mflags = 4'b0000;
  logic [15:0] res_seen;

  always #5 clk = ~clk;

  alu dut (
    .clk(clk), .rst(rst), .opcode(opcode), .alu_op(alu_op),
    .lhs(lhs), .rhs(rhs), .bubble(bubble), .result(result), .flags(flags)
  );

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic for add/sub, bit-at-a-time loops for shifts.
  task automatic ref_alu(input logic [2:0] opc, input logic [3:0] aop,
                         input logic [15:0] a, input logic [15:0] b, input logic c_in,
                         output logic [15:0] r, output logic [3:0] fl);
    int ua, ub, sa, sb, u, s, n;
    logic c, v;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    n = b[3:0];
    c = 1'b0; v = 1'b0; r = a;
    if (opc == 3'd0 || opc == 3'd1) begin
      case (aop)
        4'd0, 4'd1: begin
          u = ua + ub + ((aop == 4'd1) ? int'(c_in) : 0);
          s = sa + sb + ((aop == 4'd1) ? int'(c_in) : 0);
          r = u[15:0]; c = (u > 65535); v = (s > 32767) || (s < -32768);
        end
        4'd2, 4'd3: begin
          u = ua + (65535 - ub) + ((aop == 4'd2) ? 1 : int'(c_in));
          s = sa - sb - 1 + ((aop == 4'd2) ? 1 : int'(c_in));
          r = u[15:0]; c = (u > 65535); v = (s > 32767) || (s < -32768);
        end
        4'd4: r = a & b;
        4'd5: r = ~(a & b);
        4'd6: r = a | b;
        4'd7: r = a ^ b;
        4'd8: r = ~a;
        4'd9:  for (int i = 0; i < n; i++) begin c = r[15]; r = {r[14:0], 1'b0}; end
        4'd10: for (int i = 0; i < n; i++) begin c = r[0];  r = {1'b0, r[15:1]}; end
        4'd11: for (int i = 0; i < n; i++) begin c = r[15]; r = {r[14:0], r[15]}; end
        4'd12: for (int i = 0; i < n; i++) begin c = r[0];  r = {r[0], r[15:1]}; end
        4'd13: for (int i = 0; i < n; i++) begin c = r[0];  r = {r[15], r[15:1]}; end
        4'd14: begin r = {a[14:0], c_in}; c = a[15]; end
        default: begin r = {c_in, a[15:1]}; c = a[0]; end
      endcase
    end else if (opc == 3'd3 || opc == 3'd7) begin
      r = a;
    end else begin
      u = ua + ub; r = u[15:0];
    end
    fl = {v, r[15], (r == 16'h0000), c};
  endtask

  // Drive one instruction, check result before the edge and flags after it.
  task automatic step(input logic r_in, input logic [2:0] opc, input logic [3:0] aop,
                      input logic [15:0] a, input logic [15:0] b, input logic bub);
    logic [15:0] eres;
    logic [3:0]  efl;
    rst = r_in; opcode = opc; alu_op = aop; lhs = a; rhs = b; bubble = bub;
    #1;
    ref_alu(opc, aop, a, b, mflags[0], eres, efl);
    res_seen = result;
    check_eq("result", result, eres);
    @(posedge clk); #1;
    if (r_in) mflags = 4'b0000;
    else if (!bub && (opc == 3'd0 || opc == 3'd1)) mflags = efl;
    check_eq("flags", {12'b0, flags}, {12'b0, mflags});
  endtask

  initial begin
    step(1'b1, 3'd3, 4'd0, 16'h1111, 16'h2222, 1'b0);
    check_eq("reset_flags", {12'b0, flags}, 16'h0000);

    step(1'b0, 3'd0, 4'd0, 16'h7FFF, 16'h0001, 1'b0);
    check_eq("add_ovf_res", res_seen, 16'h8000);
    check_eq("add_ovf_flags", {12'b0, flags}, 16'h000C);

    step(1'b0, 3'd1, 4'd2, 16'h1234, 16'h1234, 1'b0);
    check_eq("cmp_eq_res", res_seen, 16'h0000);
    check_eq("cmp_eq_flags", {12'b0, flags}, 16'h0003);

    step(1'b0, 3'd0, 4'd2, 16'h0001, 16'h0002, 1'b0);
    check_eq("borrow_res", res_seen, 16'hFFFF);
    check_eq("borrow_flags", {12'b0, flags}, 16'h0004);
    step(1'b0, 3'd0, 4'd3, 16'h0005, 16'h0001, 1'b0);
    check_eq("subc_res", res_seen, 16'h0003);

    step(1'b0, 3'd0, 4'd9, 16'h8001, 16'h0001, 1'b0);
    check_eq("shl_res", res_seen, 16'h0002);
    check_eq("shl_flags", {12'b0, flags}, 16'h0001);
    step(1'b0, 3'd0, 4'd13, 16'h8000, 16'h000F, 1'b0);
    check_eq("sshr_res", res_seen, 16'hFFFF);
    step(1'b0, 3'd0, 4'd12, 16'h0001, 16'h0001, 1'b0);
    check_eq("rotr_res", res_seen, 16'h8000);
    check_eq("rotr_flags", {12'b0, flags}, 16'h0005);

    step(1'b0, 3'd5, 4'd0, 16'h0100, 16'h0004, 1'b0);
    check_eq("store_res", res_seen, 16'h0104);
    check_eq("store_flags_held", {12'b0, flags}, 16'h0005);
    step(1'b0, 3'd0, 4'd0, 16'h0000, 16'h0000, 1'b1);
    check_eq("bubble_flags_held", {12'b0, flags}, 16'h0005);

    step(1'b0, 3'd0, 4'd0, 16'h8000, 16'h8000, 1'b0);
    check_eq("all_set_flags", {12'b0, flags}, 16'h000B);
    step(1'b1, 3'd0, 4'd0, 16'h7FFF, 16'h0001, 1'b0);
    check_eq("reset_wins", {12'b0, flags}, 16'h0000);
    step(1'b1, 3'd0, 4'd0, 16'h8000, 16'h8000, 1'b1);
    check_eq("reset_bubble", {12'b0, flags}, 16'h0000);

    for (int k = 0; k < 600; k++) begin
      logic [2:0] opc;
      opc = ($urandom_range(0, 9) < 6) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
      step(($urandom_range(0, 31) == 0), opc, 4'($urandom), 16'($urandom),
           (($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 1) ? 16'h8000 : 16'h7FFF) : 16'($urandom)),
           ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
